// File: rtl/aes_pkg.sv
// Shared AES constants: Sp2V sparse encodings, slice geometry and the
// sparse state encoding of the CTR IV requester FSM.
package aes_pkg;

  // Sparse two-value encoding used on the increment handshake and write enables.
  localparam int          Sp2VWidth = 3;
  localparam logic [2:0]  SP2V_HIGH = 3'b011;
  localparam logic [2:0]  SP2V_LOW  = 3'b100;

  // Width of one counter slice written back by the counter block.
  localparam int          SliceWidth = 16;

  // Requester states; codes are pairwise at Hamming distance >= 3 so a single
  // upset cannot turn one legal state into another.
  typedef enum logic [5:0] {
    CTR_IV_IDLE  = 6'b011001,
    CTR_IV_INCR  = 6'b100110,
    CTR_IV_ACK   = 6'b110101,
    CTR_IV_ERROR = 6'b001010
  } aes_ctr_iv_req_e;

endpackage

// File: rtl/aes_sp2v_chk.sv
// Combinational Sp2V checker: flags whether a 3-bit sparse value is one of
// the two legal codes and whether it decodes to HIGH.
module aes_sp2v_chk
  import aes_pkg::*;
(
  input  logic [Sp2VWidth-1:0] sp_i,
  output logic                 valid_o,
  output logic                 is_high_o
);

  // Decode against the two legal codes only; everything else is invalid.
  always_comb begin
    is_high_o = (sp_i == SP2V_HIGH);
    valid_o   = (sp_i == SP2V_HIGH) || (sp_i == SP2V_LOW);
  end

endmodule

// File: rtl/aes_ctr_iv_req.sv
// AES CTR IV requester: holds the 128-bit IV/counter, asks the counter block
// for an increment with a sparse request, and stores back the slices the
// counter flags. Any sparse-encoding violation latches a fatal alert.
// Optional feature: define AES_CTR_IV_REQ_TIMEOUT_EN to bound how long an
// increment may wait for the counter's ready (TimeoutCycles).
module aes_ctr_iv_req
  import aes_pkg::*;
#(
  parameter int NumSlices     = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            iv_load_i,
  input  logic [NumSlices*SliceWidth-1:0] iv_i,
  input  logic                            step_req_i,
  output logic                            step_ack_o,
  output logic [Sp2VWidth-1:0]            incr_o,
  input  logic [Sp2VWidth-1:0]            ready_i,
  output logic [NumSlices*SliceWidth-1:0] ctr_o,
  input  logic [NumSlices*SliceWidth-1:0] ctr_i,
  input  logic [Sp2VWidth*NumSlices-1:0]  ctr_we_i,
  output logic [NumSlices*SliceWidth-1:0] iv_o,
  output logic                            alert_o
);

  localparam int IvWidth = NumSlices * SliceWidth;

  aes_ctr_iv_req_e         state_q, state_d;
  logic [IvWidth-1:0]      iv_q, iv_d;
  logic [IvWidth-1:0]      iv_wr;
  logic [Sp2VWidth-1:0]    incr_q, incr_d;
  logic                    ack_q, ack_d;
  logic                    alert_q, alert_d;

  logic                    ready_valid, ready_high;
  logic [NumSlices-1:0]    we_valid, we_high;
  logic                    sp_err, we_any_high;
  logic                    timeout;

  aes_sp2v_chk u_ready_chk (
    .sp_i      (ready_i),
    .valid_o   (ready_valid),
    .is_high_o (ready_high)
  );

  // One checker per slice enable; the merged value takes the counter's slice
  // where it is flagged HIGH and keeps the current IV slice otherwise.
  for (genvar gi = 0; gi < NumSlices; gi++) begin : g_slice
    aes_sp2v_chk u_we_chk (
      .sp_i      (ctr_we_i[gi*Sp2VWidth +: Sp2VWidth]),
      .valid_o   (we_valid[gi]),
      .is_high_o (we_high[gi])
    );
    assign iv_wr[gi*SliceWidth +: SliceWidth] = we_high[gi] ?
        ctr_i[gi*SliceWidth +: SliceWidth] : iv_q[gi*SliceWidth +: SliceWidth];
  end

  assign sp_err      = !ready_valid || !(&we_valid);
  assign we_any_high = |we_high;

`ifdef AES_CTR_IV_REQ_TIMEOUT_EN
  localparam int TimerW = $clog2(TimeoutCycles + 1);
  logic [TimerW-1:0] timer_q, timer_d;

  // Timer counts INCR cycles and restarts from zero on every INCR entry.
  always_comb begin
    timer_d = '0;
    if (state_q == CTR_IV_INCR) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Timer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout = (timer_q == TimerW'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state, IV update and registered-output next values.
  always_comb begin
    state_d = state_q;
    iv_d    = iv_q;
    unique case (state_q)
      CTR_IV_IDLE: begin
        if (sp_err || we_any_high) begin
          state_d = CTR_IV_ERROR;
        end else begin
          if (iv_load_i) iv_d = iv_i;
          if (step_req_i) state_d = CTR_IV_INCR;
        end
      end
      CTR_IV_INCR: begin
        if (sp_err) begin
          state_d = CTR_IV_ERROR;
        end else begin
          iv_d = iv_wr;
          if (ready_high) begin
            state_d = CTR_IV_ACK;
          end else if (timeout) begin
            state_d = CTR_IV_ERROR;
          end
        end
      end
      CTR_IV_ACK: begin
        if (sp_err || we_any_high) begin
          state_d = CTR_IV_ERROR;
        end else begin
          state_d = CTR_IV_IDLE;
        end
      end
      CTR_IV_ERROR: begin
        state_d = CTR_IV_ERROR;
      end
      default: begin
        state_d = CTR_IV_ERROR;
      end
    endcase
    incr_d  = (state_d == CTR_IV_INCR) ? SP2V_HIGH : SP2V_LOW;
    ack_d   = (state_d == CTR_IV_ACK);
    alert_d = (state_d == CTR_IV_ERROR);
  end

  // State, IV and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTR_IV_IDLE;
      iv_q    <= '0;
      incr_q  <= SP2V_LOW;
      ack_q   <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iv_q    <= iv_d;
      incr_q  <= incr_d;
      ack_q   <= ack_d;
      alert_q <= alert_d;
    end
  end

  assign step_ack_o = ack_q;
  assign incr_o     = incr_q;
  assign alert_o    = alert_q;
  assign iv_o       = iv_q;
  assign ctr_o      = iv_q;

endmodule

// File: tb/tb_aes_ctr_iv_req.sv
// Testbench for aes_ctr_iv_req: the bench plays the control FSM and the
// counter block; expected IV values are queued when an increment is driven
// and compared when step_ack_o appears.
module tb_aes_ctr_iv_req;

  localparam int         NS = 8;
  localparam logic [2:0] HI = 3'b011;
  localparam logic [2:0] LO = 3'b100;

  logic           clk = 1'b0;
  logic           rst;
  logic           iv_load;
  logic [127:0]   iv_in;
  logic           step_req;
  logic           step_ack;
  logic [2:0]     incr;
  logic [2:0]     ready;
  logic [127:0]   ctr_out;
  logic [127:0]   ctr_in;
  logic [3*NS-1:0] ctr_we;
  logic [127:0]   iv_out;
  logic           alert;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [127:0]   exp_q[$];
  logic [127:0]   iv_model;
  logic [127:0]   exp_v;

  always #5 clk = ~clk;

  aes_ctr_iv_req #(.NumSlices(NS), .TimeoutCycles(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .iv_load_i  (iv_load),
    .iv_i       (iv_in),
    .step_req_i (step_req),
    .step_ack_o (step_ack),
    .incr_o     (incr),
    .ready_i    (ready),
    .ctr_o      (ctr_out),
    .ctr_i      (ctr_in),
    .ctr_we_i   (ctr_we),
    .iv_o       (iv_out),
    .alert_o    (alert)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iv_load  = 1'b0;
    step_req = 1'b0;
    ready    = LO;
    ctr_we   = {NS{LO}};
    ctr_in   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv_in = '0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (iv_out !== 128'h0) begin n_fail++; $display("FAIL reset_iv: got %h want 0", iv_out); end
    n_checks++;
    if (incr !== LO) begin n_fail++; $display("FAIL reset_incr: got %b want %b", incr, LO); end
    n_checks++;
    if (step_ack !== 1'b0 || alert !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: ack=%b alert=%b want 0 0", step_ack, alert);
    end
    rst = 1'b0;
    tick();
    $display("reset: iv=%h incr=%b", iv_out, incr);
  endtask

  task automatic test_single_slice();
    iv_load = 1'b1;
    iv_in   = 128'hFF;
    tick();
    iv_load = 1'b0;
    n_checks++;
    if (iv_out !== 128'hFF) begin n_fail++; $display("FAIL load_idle: got %h want ff", iv_out); end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    n_checks++;
    if (incr !== HI) begin n_fail++; $display("FAIL single_incr_high: got %b want %b", incr, HI); end
    ctr_we[2:0]   = HI;
    ctr_in[15:0]  = 16'h0100;
    ready         = HI;
    iv_model      = 128'h100;
    exp_q.push_back(iv_model);
    tick();
    idle_inputs();
    n_checks++;
    if (step_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", step_ack); end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (iv_out !== exp_v) begin n_fail++; $display("FAIL single_iv: got %h want %h", iv_out, exp_v); end
    end
    n_checks++;
    if (incr !== LO) begin n_fail++; $display("FAIL single_incr_low: got %b want %b", incr, LO); end
    tick();
    n_checks++;
    if (step_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", step_ack); end
    $display("single_slice: iv=%h", iv_out);
  endtask

  task automatic test_wrap();
    iv_load  = 1'b1;
    iv_in    = '1;
    step_req = 1'b1;
    tick();
    idle_inputs();
    iv_model = '1;
    n_checks++;
    if (iv_out !== iv_model || incr !== HI) begin
      n_fail++; $display("FAIL wrap_start: iv=%h incr=%b want %h %b", iv_out, incr, iv_model, HI);
    end
    for (int j = 0; j < NS; j++) begin
      ctr_we = {NS{LO}};
      ctr_we[j*3 +: 3] = HI;
      ctr_in = '1;
      ctr_in[j*16 +: 16] = 16'h0000;
      iv_model[j*16 +: 16] = 16'h0000;
      tick();
      n_checks++;
      if (iv_out !== iv_model || incr !== HI || step_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_slice%0d: iv=%h incr=%b ack=%b want %h %b 0", j, iv_out, incr, step_ack, iv_model, HI);
      end
    end
    ctr_we = {NS{LO}};
    ready  = HI;
    exp_q.push_back(iv_model);
    tick();
    idle_inputs();
    n_checks++;
    if (step_ack !== 1'b1) begin n_fail++; $display("FAIL wrap_ack: got %b want 1", step_ack); end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (iv_out !== exp_v) begin n_fail++; $display("FAIL wrap_iv: got %h want %h", iv_out, exp_v); end
    end
    tick();
    $display("wrap: iv=%h", iv_out);
  endtask

  task automatic test_load_ignored();
    iv_load  = 1'b1;
    iv_in    = 128'h1234;
    step_req = 1'b1;
    tick();
    idle_inputs();
    iv_model = 128'h1234;
    iv_load  = 1'b1;
    iv_in    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    tick();
    iv_load = 1'b0;
    n_checks++;
    if (iv_out !== iv_model) begin n_fail++; $display("FAIL load_in_incr: got %h want %h", iv_out, iv_model); end
    ready = HI;
    exp_q.push_back(iv_model);
    tick();
    idle_inputs();
    n_checks++;
    if (step_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack: got %b want 1", step_ack); end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (iv_out !== exp_v) begin n_fail++; $display("FAIL load_ack_iv: got %h want %h", iv_out, exp_v); end
    end
    tick();
    iv_load  = 1'b1;
    iv_in    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    step_req = 1'b1;
    tick();
    idle_inputs();
    iv_model = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    n_checks++;
    if (iv_out !== iv_model || incr !== HI) begin
      n_fail++; $display("FAIL load_and_step: iv=%h incr=%b want %h %b", iv_out, incr, iv_model, HI);
    end
    ready = HI;
    exp_q.push_back(iv_model);
    tick();
    idle_inputs();
    n_checks++;
    if (step_ack !== 1'b1) begin n_fail++; $display("FAIL load_step_ack: got %b want 1", step_ack); end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (iv_out !== exp_v) begin n_fail++; $display("FAIL load_step_iv: got %h want %h", iv_out, exp_v); end
    end
    tick();
    $display("load_ignored: iv=%h", iv_out);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int last_ack = -1;
    logic [15:0] k = 16'h0001;
    step_req = 1'b1;
    ready    = HI;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (step_ack === 1'b1) begin
        acks++;
        if (last_ack >= 0) begin
          n_checks++;
          if (c - last_ack !== 3) begin n_fail++; $display("FAIL b2b_period: got %0d want 3", c - last_ack); end
        end
        last_ack = c;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          n_checks++;
          if (iv_out !== exp_v) begin n_fail++; $display("FAIL b2b_iv: got %h want %h", iv_out, exp_v); end
        end
      end
      if (incr === HI) begin
        ctr_we       = {NS{LO}};
        ctr_we[2:0]  = HI;
        ctr_in       = '0;
        ctr_in[15:0] = k;
        iv_model[15:0] = k;
        exp_q.push_back(iv_model);
        k++;
      end else begin
        ctr_we = {NS{LO}};
      end
    end
    idle_inputs();
    n_checks++;
    if (acks !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", acks); end
    exp_q.delete();
    tick();
    $display("back_to_back: acks=%0d iv=%h", acks, iv_out);
  endtask

  task automatic test_reset_mid_incr();
    int bad = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (iv_out !== 128'h0 || incr !== LO || step_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_incr: iv=%h incr=%b ack=%b want 0 %b 0", iv_out, incr, step_ack, LO);
    end
    rst = 1'b0;
    ready = HI;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (step_ack !== 1'b0 || incr !== LO) bad++;
    end
    idle_inputs();
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_no_ack: got %0d bad cycles want 0", bad); end
    iv_model = '0;
    $display("reset_mid_incr: iv=%h", iv_out);
  endtask

  task automatic test_we_error();
    int bad = 0;
    iv_load  = 1'b1;
    iv_in    = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    step_req = 1'b1;
    tick();
    idle_inputs();
    iv_model = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    ctr_we[9 +: 3] = 3'b111;
    ctr_in = '1;
    tick();
    idle_inputs();
    n_checks++;
    if (alert !== 1'b1) begin n_fail++; $display("FAIL err_alert: got %b want 1", alert); end
    n_checks++;
    if (iv_out !== iv_model) begin n_fail++; $display("FAIL err_no_write: got %h want %h", iv_out, iv_model); end
    step_req = 1'b1;
    ready    = HI;
    iv_load  = 1'b1;
    iv_in    = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (incr !== LO || step_ack !== 1'b0 || alert !== 1'b1 || iv_out !== iv_model) bad++;
    end
    idle_inputs();
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL err_sticky: got %0d bad cycles want 0", bad); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (alert !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %b want 0", alert); end
    $display("we_error: alert cleared by reset");
  endtask

  task automatic test_timeout();
    int cnt = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
`ifdef AES_CTR_IV_REQ_TIMEOUT_EN
    for (int c = 0; c < 200; c++) begin
      if (alert === 1'b1) break;
      if (incr === HI) cnt++;
      tick();
    end
    n_checks++;
    if (alert !== 1'b1 || cnt !== 64) begin
      n_fail++; $display("FAIL timeout: alert=%b incr_cycles=%0d want 1 64", alert, cnt);
    end
`else
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (alert !== 1'b0) cnt++;
    end
    n_checks++;
    if (cnt !== 0 || incr !== HI) begin
      n_fail++; $display("FAIL no_timeout: alert_cycles=%0d incr=%b want 0 %b", cnt, incr, HI);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("timeout: counted=%0d alert=%b", cnt, alert);
  endtask

  initial begin
    test_reset();
    test_single_slice();
    test_wrap();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid_incr();
    test_we_error();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
